// File: rtl/mips_register_file.sv
// ---------------------------------------------------------------------------
// mips_register_file
//
// 32-entry (2^ADDR_WIDTH) general-purpose register file for a single-cycle
// MIPS datapath, with a handshaked dump port that streams every register
// out in index order.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   Read_Register1 read port 1 index (rs)
//   Read_Register2 read port 2 index (rt)
//   Write_Register write index (from the RegDst mux: rd, rt or 31)
//   Write_Data     write data (from the writeback mux)
//   RegWrite       write enable; only a clean 1 writes
//   Read_Data1     read port 1 data, combinational
//   Read_Data2     read port 2 data, combinational
//   dump_start     request a full register dump (accepted in IDLE only)
//   dump_ready     consumer accepts the current dump beat
//   dump_valid     dump beat valid
//   dump_index     index of the current dump beat
//   dump_data      stored contents of register dump_index (no bypass)
//   dump_busy      dump in progress
//   dump_done      one-cycle pulse after the last beat is accepted
//
// Register 0 is hardwired to zero: writes to it are dropped and reads of
// index 0 always return zero. With BYPASS=1 a same-cycle write is forwarded
// to the read ports (write-first); with BYPASS=0 reads see the old value.
// ---------------------------------------------------------------------------
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Read_Register1,
    input  logic [ADDR_WIDTH-1:0] Read_Register2,
    input  logic [ADDR_WIDTH-1:0] Write_Register,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] Read_Data1,
    output logic [DATA_WIDTH-1:0] Read_Data2,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int                  NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DAT = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    dump_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_dump_index;
    logic                  r_dump_valid;
    logic                  r_dump_busy;
    logic                  r_dump_done;

    logic                  w_we;
    logic                  w_byp1;
    logic                  w_byp2;

    // Write qualifier: case equality so an unknown RegWrite never writes;
    // index 0 writes are dropped so register 0 stays zero in storage too.
    always_comb begin
        w_we = (RegWrite === 1'b1) && (Write_Register != ZERO_IDX);
    end

    // Register storage: cleared by reset, written on a qualified write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= ZERO_DAT;
            end
        end else if (w_we) begin
            r_regs[Write_Register] <= Write_Data;
        end else begin
            r_regs[Write_Register] <= r_regs[Write_Register];
        end
    end

    // Forwarding hit detection per read port (disabled when BYPASS is 0).
    always_comb begin
        w_byp1 = (BYPASS == 1) && w_we && (Write_Register == Read_Register1);
        w_byp2 = (BYPASS == 1) && w_we && (Write_Register == Read_Register2);
    end

    // Read port 1: zero for index 0, then forwarded data, then storage.
    always_comb begin
        if (Read_Register1 == ZERO_IDX) begin
            Read_Data1 = ZERO_DAT;
        end else if (w_byp1) begin
            Read_Data1 = Write_Data;
        end else begin
            Read_Data1 = r_regs[Read_Register1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if (Read_Register2 == ZERO_IDX) begin
            Read_Data2 = ZERO_DAT;
        end else if (w_byp2) begin
            Read_Data2 = Write_Data;
        end else begin
            Read_Data2 = r_regs[Read_Register2];
        end
    end

    // Dump FSM with registered handshake/status outputs. A beat advances
    // only when valid and ready are both high, so index holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dump_index <= ZERO_IDX;
            r_dump_valid <= 1'b0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dump_done  <= 1'b0;
                    r_dump_index <= ZERO_IDX;
                    if (dump_start) begin
                        r_state      <= ST_RUN;
                        r_dump_valid <= 1'b1;
                        r_dump_busy  <= 1'b1;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_dump_valid <= 1'b0;
                        r_dump_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (dump_ready && r_dump_valid) begin
                        if (r_dump_index == LAST_IDX) begin
                            r_state      <= ST_DONE;
                            r_dump_valid <= 1'b0;
                            r_dump_busy  <= 1'b0;
                            r_dump_done  <= 1'b1;
                        end else begin
                            r_dump_index <= r_dump_index + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_dump_index <= r_dump_index;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_dump_index <= ZERO_IDX;
                    r_dump_valid <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_done  <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_dump_index <= ZERO_IDX;
                    r_dump_valid <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_done  <= 1'b0;
                end
            endcase
        end
    end

    // Dump data is read straight from storage, never from the bypass path,
    // so a write to the current index shows up on the following cycle.
    always_comb begin
        dump_data  = r_regs[r_dump_index];
        dump_valid = r_dump_valid;
        dump_index = r_dump_index;
        dump_busy  = r_dump_busy;
        dump_done  = r_dump_done;
    end

endmodule

// File: tb/tb_mips_register_file.sv
module tb_mips_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Read_Register1, Read_Register2, Write_Register;
    logic [31:0] Write_Data;
    logic        RegWrite;
    logic        dump_start, dump_ready;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        dv_a, db_a, dd_a, dv_b, db_b, dd_b;
    logic [4:0]  di_a, di_b;
    logic [31:0] ddat_a, ddat_b;

    // Reference model: plain array of architectural register values.
    logic [31:0] mdl [32];

    int n_pass = 0;
    int n_tot  = 0;

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
        .Write_Register(Write_Register), .Write_Data(Write_Data), .RegWrite(RegWrite),
        .Read_Data1(rd1_a), .Read_Data2(rd2_a),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dv_a), .dump_index(di_a), .dump_data(ddat_a),
        .dump_busy(db_a), .dump_done(dd_a)
    );

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
        .Write_Register(Write_Register), .Write_Data(Write_Data), .RegWrite(RegWrite),
        .Read_Data1(rd1_b), .Read_Data2(rd2_b),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dv_b), .dump_index(di_b), .dump_data(ddat_b),
        .dump_busy(db_b), .dump_done(dd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected read value straight from the architectural rules.
    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'd0;
        if (byp && (RegWrite === 1'b1) && (Write_Register == idx)) return Write_Data;
        return mdl[idx];
    endfunction

    // One clock: update the model with what the edge commits, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if ((RegWrite === 1'b1) && (Write_Register != 5'd0)) begin
            mdl[Write_Register] = Write_Data;
        end
        #1;
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_rd1_byp"},   rd1_a, exp_read(Read_Register1, 1'b1));
        chk({tag, "_rd2_byp"},   rd2_a, exp_read(Read_Register2, 1'b1));
        chk({tag, "_rd1_nobyp"}, rd1_b, exp_read(Read_Register1, 1'b0));
        chk({tag, "_rd2_nobyp"}, rd2_b, exp_read(Read_Register2, 1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Read_Register1 = 5'(i);
            Read_Register2 = 5'(31 - i);
            #1;
            chk({tag, "_a1"}, rd1_a, 32'd0);
            chk({tag, "_a2"}, rd2_a, 32'd0);
            chk({tag, "_b1"}, rd1_b, 32'd0);
            chk({tag, "_b2"}, rd2_b, 32'd0);
        end
    endtask

    // Full dump. pattern=0: ready held high, exact latency checked.
    // pattern=1: ready 1,0,0 repeating, extra start pulse, write to r31 at beat 10.
    task automatic run_dump(input bit pattern);
        int  beat  = 0;
        int  c     = 0;
        bit  seen  = 1'b0;
        bit  wrote = 1'b0;
        dump_start = 1'b1;
        dump_ready = 1'b0;
        RegWrite   = 1'b0;
        tick();
        dump_start = 1'b0;
        c = 1;
        while (!seen && c < 300) begin
            if (dd_a) begin
                seen = 1'b1;
            end else begin
                chk("dump_valid", 32'(dv_a), 32'd1);
                chk("dump_busy",  32'(db_a), 32'd1);
                chk("dump_index", 32'(di_a), 32'(beat));
                chk("dump_data",  ddat_a, mdl[beat[4:0]]);
                chk("dump_index_b", 32'(di_b), 32'(beat));
                if (pattern && beat == 31) chk("dump_r31_new", ddat_a, 32'hCAFE0031);
                RegWrite = 1'b0;
                if (pattern && beat == 10 && !wrote) begin
                    RegWrite       = 1'b1;
                    Write_Register = 5'd31;
                    Write_Data     = 32'hCAFE0031;
                    wrote          = 1'b1;
                end
                dump_start = pattern && (c == 7);
                dump_ready = pattern ? ((c % 3) == 1) : 1'b1;
                if (dump_ready) beat++;
                tick();
                c++;
            end
        end
        chk("dump_done_seen", 32'(seen), 32'd1);
        chk("dump_beats", 32'(beat), 32'd32);
        if (!pattern) chk("dump_done_cycle", 32'(c), 32'd33);
        chk("done_busy", 32'(db_a), 32'd0);
        chk("done_valid", 32'(dv_a), 32'd0);
        chk("done_b", 32'(dd_b), 32'd1);
        RegWrite   = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        tick();
        chk("done_pulse_len", 32'(dd_a), 32'd0);
        chk("idle_valid", 32'(dv_a), 32'd0);
        chk("idle_index", 32'(di_a), 32'd0);
        tick();
        chk("no_restart", 32'(dv_a), 32'd0);
    endtask

    typedef struct {
        logic [4:0]  rr1, rr2, wr;
        logic [31:0] wd;
        logic        we;
        logic [31:0] e1b, e2b, e1n, e2n;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{5'd8,  5'd0,  5'd8,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        tbl[1] = '{5'd8,  5'd8,  5'd0,  32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[3] = '{5'd31, 5'd8,  5'd31, 32'h00400024, 1'b1, 32'h00400024, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{5'd31, 5'd0,  5'd0,  32'h0,        1'b0, 32'h00400024, 32'h0,        32'h00400024, 32'h0};
        tbl[5] = '{5'd5,  5'd5,  5'd5,  32'h12345678, 1'b1, 32'h12345678, 32'h12345678, 32'h0,        32'h0};
        tbl[6] = '{5'd5,  5'd8,  5'd5,  32'h00000001, 1'b1, 32'h00000001, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        tbl[7] = '{5'd5,  5'd31, 5'd0,  32'h0,        1'b0, 32'h00000001, 32'h00400024, 32'h00000001, 32'h00400024};

        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst_n = 1'b0; RegWrite = 1'b0; Write_Register = 5'd0; Write_Data = 32'd0;
        Read_Register1 = 5'd0; Read_Register2 = 5'd0; dump_start = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(dv_a), 32'd0);
        chk("rst_busy",  32'(db_a), 32'd0);
        chk("rst_done",  32'(dd_a), 32'd0);
        chk("rst_index", 32'(di_a), 32'd0);
        check_all_zero("rst_read");

        run_dump(1'b0);

        // Directed vectors from a clean register file.
        for (int i = 0; i < 8; i++) begin
            Read_Register1 = tbl[i].rr1; Read_Register2 = tbl[i].rr2;
            Write_Register = tbl[i].wr;  Write_Data = tbl[i].wd; RegWrite = tbl[i].we;
            #1;
            chk("vec_rd1_byp",   rd1_a, tbl[i].e1b);
            chk("vec_rd2_byp",   rd2_a, tbl[i].e2b);
            chk("vec_rd1_nobyp", rd1_b, tbl[i].e1n);
            chk("vec_rd2_nobyp", rd2_b, tbl[i].e2n);
            tick();
        end

        // Unknown write enable on the link register must not write.
        RegWrite = 1'bx; Write_Register = 5'd31; Write_Data = 32'd0; Read_Register1 = 5'd31;
        #1;
        chk("x_we_same_cycle", rd1_a, exp_read(5'd31, 1'b1));
        tick();
        RegWrite = 1'b0;
        #1;
        chk("x_we_r31_a", rd1_a, mdl[31]);
        chk("x_we_r31_b", rd1_b, mdl[31]);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            Read_Register1 = 5'($urandom_range(0, 31));
            Read_Register2 = ($urandom_range(0, 3) == 0) ? Read_Register1 : 5'($urandom_range(0, 31));
            Write_Register = ($urandom_range(0, 3) == 0) ? Read_Register1 : 5'($urandom_range(0, 31));
            Write_Data     = $urandom;
            RegWrite       = ($urandom_range(0, 2) != 0);
            #1;
            check_reads("rand");
            tick();
        end
        RegWrite = 1'b0;

        run_dump(1'b1);

        // Reset during beat 15 aborts the dump.
        begin
            int guard = 0;
            dump_ready = 1'b0; dump_start = 1'b1;
            tick();
            dump_start = 1'b0; dump_ready = 1'b1;
            while (di_a != 5'd15 && guard < 40) begin
                tick();
                guard++;
            end
            chk("reach_beat15", 32'(di_a), 32'd15);
            chk("beat15_valid", 32'(dv_a), 32'd1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("abort_valid", 32'(dv_a), 32'd0);
            chk("abort_busy",  32'(db_a), 32'd0);
            chk("abort_done",  32'(dd_a), 32'd0);
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("abort_no_done", 32'(dd_a), 32'd0);
            end
            dump_ready = 1'b0;
            check_all_zero("abort_read");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
